// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC/fetch front end.
// Holds the FSM encoding, the buffer entry layout and small address helpers.
package pc_fetch_unit_pkg;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } buf_entry_t;

    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
    localparam logic [31:0] INSN_BYTES = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch unit bus: redirect input, imem request/response, and decode-side instruction stream.
// out_fetch_misaligned exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface pc_fetch_unit_if;
    logic        in_redirect_valid;
    logic [31:0] in_redirect_pc;
    logic        out_imem_req_valid;
    logic [31:0] out_imem_req_addr;
    logic        in_imem_req_ready;
    logic        in_imem_resp_valid;
    logic [31:0] in_imem_resp_data;
    logic        out_inst_valid;
    logic [31:0] out_inst_data;
    logic [31:0] out_inst_pc;
    logic        in_inst_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        out_fetch_misaligned;
`endif

    modport master (
        input  in_redirect_valid, in_redirect_pc,
        output out_imem_req_valid, out_imem_req_addr,
        input  in_imem_req_ready, in_imem_resp_valid, in_imem_resp_data,
        output out_inst_valid, out_inst_data, out_inst_pc,
        input  in_inst_ready
`ifdef FETCH_MISALIGN_TRAP_EN
        , output out_fetch_misaligned
`endif
    );

    modport slave (
        output in_redirect_valid, in_redirect_pc,
        input  out_imem_req_valid, out_imem_req_addr,
        output in_imem_req_ready, in_imem_resp_valid, in_imem_resp_data,
        input  out_inst_valid, out_inst_data, out_inst_pc,
        output in_inst_ready
`ifdef FETCH_MISALIGN_TRAP_EN
        , input out_fetch_misaligned
`endif
    );
endinterface

// File: rtl/pc_fetch_unit_fetch_buffer.sv
// Circular fetch buffer with alloc/fill/head pointers; entries hold {pc, data} plus a filled flag.
// Latency: fill becomes head_valid the next cycle (registered, no bypass).
// Backpressure: caller gates alloc by alloc_cnt; fills always have a slot; flush frees everything.
module fetch_buffer
    import pc_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc_en,
    input  logic [31:0]              alloc_pc,
    input  logic                     fill_en,
    input  logic [31:0]              fill_data,
    input  logic                     pop_en,
    output logic                     head_valid,
    output logic [31:0]              head_pc,
    output logic [31:0]              head_data,
    output logic [$clog2(DEPTH):0]   alloc_cnt,
    output logic [$clog2(DEPTH):0]   unfilled_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    buf_entry_t       ent_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [AW:0]      alloc_ptr, fill_ptr, head_ptr;
    logic [AW-1:0]    alloc_idx, fill_idx, head_idx;
    logic             pop_ok;

    assign alloc_idx = alloc_ptr[AW-1:0];
    assign fill_idx  = fill_ptr[AW-1:0];
    assign head_idx  = head_ptr[AW-1:0];
    assign pop_ok    = pop_en && filled_q[head_idx];

    // Flush realigns fill/head onto alloc so the ring restarts empty where it stands.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            filled_q  <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else if (flush) begin
            fill_ptr <= alloc_ptr;
            head_ptr <= alloc_ptr;
            filled_q <= '0;
        end else begin
            if (alloc_en) begin
                ent_q[alloc_idx].pc <= alloc_pc;
                alloc_ptr           <= alloc_ptr + PTR_ONE;
            end
            if (fill_en) begin
                ent_q[fill_idx].data <= fill_data;
                filled_q[fill_idx]   <= 1'b1;
                fill_ptr             <= fill_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                filled_q[head_idx] <= 1'b0;
                head_ptr           <= head_ptr + PTR_ONE;
            end
        end
    end

    assign head_valid   = filled_q[head_idx];
    assign head_pc      = ent_q[head_idx].pc;
    assign head_data    = ent_q[head_idx].data;
    assign alloc_cnt    = alloc_ptr - head_ptr;
    assign unfilled_cnt = alloc_ptr - fill_ptr;
endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and in-order word fetcher feeding decode; optional FETCH_MISALIGN_TRAP_EN misaligned-redirect trap.
// Latency: request issued cycle after redirect; response visible at out_inst one cycle after arrival.
// Backpressure: issue stops when allocated + still-to-drop reaches FIFO_DEPTH; responses never stalled.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_unit_if.master bus
);
    localparam int             CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_V  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]  DROP_ONE = 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q;
    logic [31:0]   redirect_target;
    logic [CW-1:0] drop_cnt_q;
    logic [CW-1:0] alloc_cnt, unfilled_cnt;
    logic [CW:0]   occupancy;
    logic          issue_ok, req_fire, fill_en, pop_en, head_valid, misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;

    always_ff @(posedge clk) begin
        if (rst)                        misaligned_q <= 1'b0;
        else if (bus.in_redirect_valid) misaligned_q <= |bus.in_redirect_pc[1:0];
    end

    assign misaligned               = misaligned_q;
    assign bus.out_fetch_misaligned = misaligned_q;
    assign redirect_target          = bus.in_redirect_pc;
`else
    assign misaligned      = 1'b0;
    assign redirect_target = align_word(bus.in_redirect_pc);
`endif

    // Words still owed by memory for flushed requests count against capacity until they drain.
    assign occupancy = {1'b0, alloc_cnt} + {1'b0, drop_cnt_q};

    always_comb begin
        state_d  = state_q;
        issue_ok = 1'b0;
        unique case (state_q)
            S_BOOT: state_d  = S_RUN;
            S_RUN:  issue_ok = !bus.in_redirect_valid && !misaligned && (occupancy < DEPTH_V);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_BOOT;
        else     state_q <= state_d;
    end

    assign req_fire = issue_ok && bus.in_imem_req_ready;
    assign fill_en  = bus.in_imem_resp_valid && (drop_cnt_q == '0) && !bus.in_redirect_valid;
    assign pop_en   = head_valid && bus.in_inst_ready && !bus.in_redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else if (bus.in_redirect_valid) begin
            pc_q       <= redirect_target;
            drop_cnt_q <= drop_cnt_q + unfilled_cnt - {{(CW-1){1'b0}}, bus.in_imem_resp_valid};
        end else begin
            if (req_fire) pc_q <= pc_q + INSN_BYTES;
            if (bus.in_imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_q <= drop_cnt_q - DROP_ONE;
        end
    end

    fetch_buffer #(.DEPTH(FIFO_DEPTH)) u_buf (
        .clk          (clk),
        .rst          (rst),
        .flush        (bus.in_redirect_valid),
        .alloc_en     (req_fire),
        .alloc_pc     (pc_q),
        .fill_en      (fill_en),
        .fill_data    (bus.in_imem_resp_data),
        .pop_en       (pop_en),
        .head_valid   (head_valid),
        .head_pc      (bus.out_inst_pc),
        .head_data    (bus.out_inst_data),
        .alloc_cnt    (alloc_cnt),
        .unfilled_cnt (unfilled_cnt)
    );

    assign bus.out_imem_req_valid = issue_ok;
    assign bus.out_imem_req_addr  = pc_q;
    assign bus.out_inst_valid     = head_valid;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: memory model with grant budget and latency, scoreboard queues
// for expected requests and delivered instructions, checked by an independent negedge monitor.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic clk;
    logic rst;
    pc_fetch_unit_if bus();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 0;
    int          grant_left = 0;
    int          mem_lat = 1;
    int          cyc = 0;
    logic [31:0] exp_req[$];
    buf_entry_t  exp_inst[$];
    pend_t       pend[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Memory: accepts while grant_left > 0, answers in order after mem_lat cycles, data = 0x1000_0000 + addr.
    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        bus.in_imem_req_ready  = 1'b0;
        bus.in_imem_resp_valid = 1'b0;
        bus.in_imem_resp_data  = NOP_INSN;
        forever begin
            @(negedge clk);
            acc      = bus.out_imem_req_valid && bus.in_imem_req_ready;
            acc_addr = bus.out_imem_req_addr;
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                pend.delete();
                acc = 1'b0;
            end
            if (acc) begin
                pend.push_back('{addr: acc_addr, due: cyc + mem_lat - 1});
                grant_left--;
            end
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                bus.in_imem_resp_valid = 1'b1;
                bus.in_imem_resp_data  = 32'h1000_0000 + pend[0].addr;
                void'(pend.pop_front());
            end else begin
                bus.in_imem_resp_valid = 1'b0;
                bus.in_imem_resp_data  = NOP_INSN;
            end
            bus.in_imem_req_ready = (grant_left > 0);
        end
    end

    // Monitor: every accepted request and every delivered instruction must match the scoreboard head.
    initial begin
        logic [31:0] e_addr;
        buf_entry_t  e_inst;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (bus.out_imem_req_valid && bus.in_imem_req_ready) begin
                    if (exp_req.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL req_unexpected: got request %h, none expected", bus.out_imem_req_addr);
                    end else begin
                        e_addr = exp_req.pop_front();
                        check32("req_addr", bus.out_imem_req_addr, e_addr);
                    end
                end
                if (bus.out_inst_valid && bus.in_inst_ready && !bus.in_redirect_valid) begin
                    if (exp_inst.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL inst_unexpected: got pc %h data %h, none expected",
                                 bus.out_inst_pc, bus.out_inst_data);
                    end else begin
                        e_inst = exp_inst.pop_front();
                        check32("inst_pc", bus.out_inst_pc, e_inst.pc);
                        check32("inst_data", bus.out_inst_data, e_inst.data);
                    end
                end
            end
        end
    end

    task automatic do_reset;
        mon_en                = 1'b0;
        rst                   = 1'b1;
        bus.in_redirect_valid = 1'b0;
        bus.in_redirect_pc    = 32'h0;
        bus.in_inst_ready     = 1'b0;
        grant_left            = 0;
        mem_lat               = 1;
        exp_req.delete();
        exp_inst.delete();
        tick();
        tick();
        @(negedge clk);
        check32("rst_req_valid", {31'b0, bus.out_imem_req_valid}, 32'h0);
        check32("rst_inst_valid", {31'b0, bus.out_inst_valid}, 32'h0);
        check32("rst_req_addr", bus.out_imem_req_addr, 32'h0);
        check32("rst_inst_pc", bus.out_inst_pc, 32'h0);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check32("boot_no_req", {31'b0, bus.out_imem_req_valid}, 32'h0);
        tick();
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        bus.in_redirect_valid = 1'b1;
        bus.in_redirect_pc    = target;
        tick();
        bus.in_redirect_valid = 1'b0;
    endtask

    task automatic push_fetch(input logic [31:0] a, input logic [31:0] d);
        exp_req.push_back(a);
        exp_inst.push_back('{pc: a, data: d});
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && (exp_req.size() != 0 || exp_inst.size() != 0); i++) tick();
        for (int i = 0; i < 6; i++) tick();
        check32({name, "_req_left"}, exp_req.size(), 32'd0);
        check32({name, "_inst_left"}, exp_inst.size(), 32'd0);
    endtask

    task automatic wait_grant_used(input string name);
        int i;
        for (i = 0; i < 30 && grant_left != 0; i++) tick();
        if (grant_left != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: grant left %0d required 0", name, grant_left);
        end
    endtask

    initial begin
        rst                   = 1'b1;
        bus.in_redirect_valid = 1'b0;
        bus.in_redirect_pc    = 32'h0;
        bus.in_inst_ready     = 1'b0;

        // Basic in-order stream of four words.
        do_reset();
        bus.in_inst_ready = 1'b1;
        push_fetch(32'h0000_0000, 32'h1000_0000);
        push_fetch(32'h0000_0004, 32'h1000_0004);
        push_fetch(32'h0000_0008, 32'h1000_0008);
        push_fetch(32'h0000_000C, 32'h1000_000C);
        grant_left = 4;
        wait_drain("stream", 40);

        // Decode stalled: exactly FIFO_DEPTH requests, then one more per pop.
        do_reset();
        exp_req.push_back(32'h0000_0000);
        exp_req.push_back(32'h0000_0004);
        exp_req.push_back(32'h0000_0008);
        exp_req.push_back(32'h0000_000C);
        grant_left = 100;
        wait_drain("full", 40);
        @(negedge clk);
        check32("full_no_req", {31'b0, bus.out_imem_req_valid}, 32'h0);
        check32("full_head_valid", {31'b0, bus.out_inst_valid}, 32'h1);
        tick();
        exp_inst.push_back('{pc: 32'h0000_0000, data: 32'h1000_0000});
        exp_req.push_back(32'h0000_0010);
        bus.in_inst_ready = 1'b1;
        tick();
        bus.in_inst_ready = 1'b0;
        wait_drain("refill", 40);
        @(negedge clk);
        check32("refill_no_req", {31'b0, bus.out_imem_req_valid}, 32'h0);
        tick();

        // Redirect with two requests in flight: their responses are dropped.
        do_reset();
        bus.in_inst_ready = 1'b1;
        mem_lat           = 4;
        exp_req.push_back(32'h0000_0000);
        exp_req.push_back(32'h0000_0004);
        push_fetch(32'h0000_0100, 32'h1000_0100);
        push_fetch(32'h0000_0104, 32'h1000_0104);
        grant_left = 2;
        wait_grant_used("inflight");
        grant_left = 2;
        pulse_redirect(32'h0000_0100);
        wait_drain("redirect", 60);

        // Redirect coinciding with a response and a pop.
        do_reset();
        exp_req.push_back(32'h0000_0000);
        exp_req.push_back(32'h0000_0004);
        grant_left = 2;
        wait_grant_used("coincide");
        bus.in_inst_ready = 1'b1;
        pulse_redirect(32'h0000_0200);
        @(negedge clk);
        check32("coincide_no_inst", {31'b0, bus.out_inst_valid}, 32'h0);
        check32("coincide_pc", bus.out_imem_req_addr, 32'h0000_0200);
        tick();
        push_fetch(32'h0000_0200, 32'h1000_0200);
        grant_left = 1;
        wait_drain("coincide", 40);

        // PC wraps past the top of the address space.
        do_reset();
        bus.in_inst_ready = 1'b1;
        pulse_redirect(32'hFFFF_FFFC);
        @(negedge clk);
        check32("wrap_start_addr", bus.out_imem_req_addr, 32'hFFFF_FFFC);
        tick();
        push_fetch(32'hFFFF_FFFC, 32'h0FFF_FFFC);
        push_fetch(32'h0000_0000, 32'h1000_0000);
        grant_left = 2;
        wait_drain("wrap", 40);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect traps and blocks issue until an aligned redirect.
        do_reset();
        bus.in_inst_ready = 1'b1;
        pulse_redirect(32'h0000_0102);
        grant_left = 4;
        for (int i = 0; i < 8; i++) tick();
        @(negedge clk);
        check32("mis_flag_set", {31'b0, bus.out_fetch_misaligned}, 32'h1);
        check32("mis_no_req", {31'b0, bus.out_imem_req_valid}, 32'h0);
        tick();
        push_fetch(32'h0000_0200, 32'h1000_0200);
        push_fetch(32'h0000_0204, 32'h1000_0204);
        push_fetch(32'h0000_0208, 32'h1000_0208);
        push_fetch(32'h0000_020C, 32'h1000_020C);
        pulse_redirect(32'h0000_0200);
        @(negedge clk);
        check32("mis_flag_clear", {31'b0, bus.out_fetch_misaligned}, 32'h0);
        tick();
        wait_drain("mis_resume", 40);
`else
        // Low target bits are ignored without the trap.
        do_reset();
        bus.in_inst_ready = 1'b1;
        pulse_redirect(32'h0000_010A);
        @(negedge clk);
        check32("align_addr", bus.out_imem_req_addr, 32'h0000_0108);
        tick();
        push_fetch(32'h0000_0108, 32'h1000_0108);
        grant_left = 1;
        wait_drain("align", 40);
`endif

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
